nr_div_scheduler: RTL and testbench



---
 rtl/nr_div_scheduler.sv | 157 +++++++++++++++
 tb/tb_nr_div_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nr_div_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nr_div_scheduler: round-robin arbiter sharing one Newton-Raphson divider |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module nr_div_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ITERS   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [16*N_REQ-1:0] req_nr,
  input  logic [16*N_REQ-1:0] req_dr,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [15:0]         rsp_res,
  output logic                rsp_err,
  output logic                div_start,
  output logic [15:0]         div_nr,
  output logic [15:0]         div_dr,
  output logic [15:0]         div_guess,
  output logic [7:0]          div_iters,
  input  logic                div_done,
  input  logic [15:0]         div_res
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q, ptr_d, idx_q;
  logic [CW-1:0]   cnt_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [15:0]     rsp_res_q, nr_q, dr_q, guess_q;
  logic            rsp_err_q, div_start_q;

  logic            hi_vld, lo_vld, grant_vld;
  logic [IW-1:0]   hi_idx, lo_idx, grant_idx;
  logic [15:0]     sel_nr, sel_dr, seed_mag, seed;
  logic [16:0]     dr_mag;
  logic [4:0]      lead_pos;
  logic [31:0]     seed_wide;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_vld = 1'b1;
        lo_idx = IW'(i);
        if (i >= int'(ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
  end

  assign grant_vld = lo_vld;
  assign grant_idx = hi_vld ? hi_idx : lo_idx;
  assign ptr_d     = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
  assign req_ready = (state_q == IDLE && grant_vld) ? (ONE << grant_idx) : '0;
  assign sel_nr    = req_nr[{grant_idx, 4'b0000} +: 16];
  assign sel_dr    = req_dr[{grant_idx, 4'b0000} +: 16];

  // Magnitude in 17 bits so that -32768 maps to +32768 without overflow.
  assign dr_mag = sel_dr[15] ? (17'd0 - {1'b1, sel_dr}) : {1'b0, sel_dr};

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < 17; i++) begin
      if (dr_mag[i]) lead_pos = 5'(i);
    end
  end

  assign seed_wide = 32'd3 << (5'd18 - lead_pos);
  assign seed_mag  = (seed_wide > 32'h0000_7FFF) ? 16'h7FFF : seed_wide[15:0];
  assign seed      = sel_dr[15] ? (16'd0 - seed_mag) : seed_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_err_q   <= 1'b0;
      div_start_q <= 1'b0;
      nr_q        <= '0;
      dr_q        <= '0;
      guess_q     <= '0;
    end else begin
      div_start_q <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            idx_q   <= grant_idx;
            ptr_q   <= ptr_d;
            nr_q    <= sel_nr;
            dr_q    <= sel_dr;
            guess_q <= seed;
            if (sel_dr == 16'd0) begin
              rsp_res_q   <= sel_nr[15] ? 16'h8000 : 16'h7FFF;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= ONE << grant_idx;
              state_q     <= RESP;
            end else begin
              div_start_q <= 1'b1;
              state_q     <= START;
            end
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            rsp_res_q   <= div_res;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= ONE << idx_q;
            state_q     <= RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_res_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= ONE << idx_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_err   = rsp_err_q;
  assign div_start = div_start_q;
  assign div_nr    = nr_q;
  assign div_dr    = dr_q;
  assign div_guess = guess_q;
  assign div_iters = 8'(ITERS);

endmodule
`default_nettype wire

// File: tb/tb_nr_div_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nr_div_scheduler: directed self-checking bench for nr_div_scheduler   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_nr_div_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [16*N-1:0] req_nr, req_dr;
  logic [N-1:0]  rsp_valid;
  logic [15:0]   rsp_res;
  logic          rsp_err;
  logic          div_start;
  logic [15:0]   div_nr, div_dr, div_guess;
  logic [7:0]    div_iters;
  logic          div_done;
  logic [15:0]   div_res;

  int errors = 0;
  int checks = 0;

  nr_div_scheduler #(.N_REQ(N), .ITERS(8), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_nr(req_nr), .req_dr(req_dr),
    .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_err(rsp_err),
    .div_start(div_start), .div_nr(div_nr), .div_dr(div_dr),
    .div_guess(div_guess), .div_iters(div_iters),
    .div_done(div_done), .div_res(div_res)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] nr, input logic [15:0] dr);
    req_nr[16*i +: 16] = nr;
    req_dr[16*i +: 16] = dr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, div_start} !== '0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0", {req_ready, rsp_valid, rsp_err, div_start});
    end
    checks++;
    if ({div_nr, div_dr, div_guess, rsp_res} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {div_nr, div_dr, div_guess, rsp_res});
    end
    checks++;
    if (div_iters !== 8'd8) begin
      errors++;
      $display("FAIL iters: got %0d expected 8", div_iters);
    end
  endtask

  task automatic test_single();
    set_req(0, 16'h0C00, 16'h0800);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b expected 0001", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if ({div_start, div_nr, div_dr, div_guess} !== {1'b1, 16'h0C00, 16'h0800, 16'h0180}) begin
      errors++;
      $display("FAIL single_start: got start=%b nr=%h dr=%h guess=%h expected 1 0c00 0800 0180",
               div_start, div_nr, div_dr, div_guess);
    end
    tick();
    checks++;
    if (div_start !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_pulse: got start=%b ready=%b expected 0 0000", div_start, req_ready);
    end
    tick();
    div_done = 1'b1;
    div_res  = 16'h0600;
    #1;
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_early_rsp: got %b expected 0000", rsp_valid);
    end
    tick();
    div_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_res, rsp_err} !== {4'b0001, 16'h0600, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp: got v=%b res=%h err=%b expected 0001 0600 0", rsp_valid, rsp_res, rsp_err);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_rsp_width: got %b expected 0000", rsp_valid);
    end
  endtask

  task automatic test_seed();
    logic [15:0] drs [7];
    logic [15:0] exp_g [7];
    drs   = '{16'hFC00, 16'h0001, 16'h8000, 16'h0010, 16'h0020, 16'hFFFF, 16'h7FFF};
    exp_g = '{16'hFD00, 16'h7FFF, 16'hFFE8, 16'h7FFF, 16'h6000, 16'h8001, 16'h0030};
    for (int k = 0; k < 7; k++) begin
      set_req(0, 16'h0400, drs[k]);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      checks++;
      if (div_guess !== exp_g[k] || div_dr !== drs[k]) begin
        errors++;
        $display("FAIL seed_%0d: got guess=%h dr=%h expected %h %h", k, div_guess, div_dr, exp_g[k], drs[k]);
      end
      tick();
      div_done = 1'b1;
      div_res  = ~drs[k];
      tick();
      div_done = 1'b0;
      checks++;
      if ({rsp_valid, rsp_res, rsp_err} !== {4'b0001, ~drs[k], 1'b0}) begin
        errors++;
        $display("FAIL seed_rsp_%0d: got v=%b res=%h err=%b expected 0001 %h 0",
                 k, rsp_valid, rsp_res, rsp_err, ~drs[k]);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_r;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 16'h0400, 16'h0400);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_r = 4'b0001 << (g % N);
      #1;
      checks++;
      if (req_ready !== exp_r) begin
        errors++;
        $display("FAIL rr_grant_%0d: got %b expected %b", g, req_ready, exp_r);
      end
      tick();
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL rr_busy_%0d: got %b expected 0000", g, req_ready);
      end
      tick();
      div_done = 1'b1;
      div_res  = 16'(16'h0100 + g);
      tick();
      div_done = 1'b0;
      checks++;
      if ({rsp_valid, rsp_res, req_ready} !== {exp_r, 16'(16'h0100 + g), 4'b0000}) begin
        errors++;
        $display("FAIL rr_rsp_%0d: got v=%b res=%h ready=%b expected %b %h 0000",
                 g, rsp_valid, rsp_res, req_ready, exp_r, 16'(16'h0100 + g));
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_div_zero();
    set_req(1, 16'hF000, 16'h0000);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL dz_ready: got %b expected 0010", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if ({rsp_valid, rsp_res, rsp_err, div_start} !== {4'b0010, 16'h8000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dz_neg: got v=%b res=%h err=%b start=%b expected 0010 8000 1 0",
               rsp_valid, rsp_res, rsp_err, div_start);
    end
    tick();
    set_req(2, 16'h0100, 16'h0000);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    checks++;
    if ({rsp_valid, rsp_res, rsp_err, div_start} !== {4'b0100, 16'h7FFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dz_pos: got v=%b res=%h err=%b start=%b expected 0100 7fff 1 0",
               rsp_valid, rsp_res, rsp_err, div_start);
    end
    tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    set_req(3, 16'h0400, 16'h0400);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    for (int c = 1; c < 12; c++) begin
      if (rsp_valid !== 4'b0000) early++;
      tick();
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d early strobes expected 0", early);
    end
    checks++;
    if ({rsp_valid, rsp_res, rsp_err} !== {4'b1000, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL timeout_rsp: got v=%b res=%h err=%b expected 1000 0000 1", rsp_valid, rsp_res, rsp_err);
    end
    tick();
    tick();
    div_done = 1'b1;
    div_res  = 16'h1234;
    tick();
    div_done = 1'b0;
    early = 0;
    for (int c = 0; c < 3; c++) begin
      if (rsp_valid !== 4'b0000) early++;
      tick();
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_stray: got %0d strobes expected 0", early);
    end
  endtask

  task automatic test_reset_mid_wait();
    int stray;
    stray = 0;
    set_req(1, 16'h0800, 16'h0400);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_res, rsp_err, div_start, div_nr, div_dr, div_guess} !== '0) begin
      errors++;
      $display("FAIL rst_wait_outputs: got v=%b res=%h err=%b start=%b nr=%h dr=%h guess=%h expected all 0",
               rsp_valid, rsp_res, rsp_err, div_start, div_nr, div_dr, div_guess);
    end
    checks++;
    if (dut.ptr_q !== 2'd0) begin
      errors++;
      $display("FAIL rst_wait_ptr: got %0d expected 0", dut.ptr_q);
    end
    div_done = 1'b1;
    div_res  = 16'h5555;
    tick();
    div_done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (rsp_valid !== 4'b0000 || div_start !== 1'b0) stray++;
      tick();
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rst_wait_stray: got %0d strobes expected 0", stray);
    end
    set_req(2, 16'h0C00, 16'h0400);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rst_wait_regrant: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if ({div_start, div_guess} !== {1'b1, 16'h0300}) begin
      errors++;
      $display("FAIL rst_wait_start: got start=%b guess=%h expected 1 0300", div_start, div_guess);
    end
    tick();
    div_done = 1'b1;
    div_res  = 16'h0C00;
    tick();
    div_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_res, rsp_err} !== {4'b0100, 16'h0C00, 1'b0}) begin
      errors++;
      $display("FAIL rst_wait_rsp: got v=%b res=%h err=%b expected 0100 0c00 0", rsp_valid, rsp_res, rsp_err);
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_nr    = '0;
    req_dr    = '0;
    div_done  = 1'b0;
    div_res   = '0;
    #1;
    test_reset();
    test_single();
    test_seed();
    test_round_robin();
    test_div_zero();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
